// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty integer clock divider with boundary-aligned ratio changes and start/stop.
// Optional period counter enabled by defining CLK_DIV_CTRL_PERIOD_STAT_EN.
//
// state     | meaning
// IDLE      | divider stopped, clk_out low, cnt held at 0
// RUN       | counting 0..cur_div-1, one divided period per wrap
// STOP_PEND | en dropped, finishing the current period before IDLE
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_req,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic [CNT_W-1:0] cur_div,
   output logic             clk_out,
   output logic             period_start,
   output logic             busy,
   output logic [15:0]      period_cnt
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] div_eff;
   logic             clk_p;
   logic             clk_n;
   logic             req_armed;
   logic             req_take;
   logic             div_ok;
   logic             wrap;

   always_comb begin
      half     = cur_div >> 1;
      cnt_inc  = cnt + ONE;
      wrap     = (state != IDLE) && (cnt == (cur_div - ONE));
      div_ok   = (div_val >= TWO);
      req_take = div_req && req_armed && ((state == IDLE) || wrap);
      div_eff  = (req_take && div_ok) ? div_val : cur_div;
      case (state)
         IDLE:      state_nxt = en ? RUN : IDLE;
         RUN,
         STOP_PEND: begin
            if (wrap) state_nxt = en ? RUN : IDLE;
            else      state_nxt = en ? RUN : STOP_PEND;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // Entering RUN preloads cnt to the wrap value so clk_out rises on the very next posedge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         cur_div      <= CNT_W'(DEF_DIV);
         clk_p        <= 1'b0;
         div_ack      <= 1'b0;
         div_err      <= 1'b0;
         period_start <= 1'b0;
         busy         <= 1'b0;
         req_armed    <= 1'b0;
      end else begin
         state        <= state_nxt;
         busy         <= (state_nxt != IDLE);
         div_ack      <= req_take;
         div_err      <= req_take && !div_ok;
         cur_div      <= div_eff;
         period_start <= 1'b0;
         if (req_take)
            req_armed <= 1'b0;
         else if (!div_req)
            req_armed <= 1'b1;
         case (state)
            IDLE: begin
               clk_p <= 1'b0;
               cnt   <= en ? (div_eff - ONE) : '0;
            end
            default: begin
               if (wrap) begin
                  cnt          <= '0;
                  clk_p        <= (state_nxt == RUN);
                  period_start <= (state_nxt == RUN);
               end else begin
                  cnt   <= cnt_inc;
                  clk_p <= (cnt_inc < half);
               end
            end
         endcase
      end
   end

   // Half-cycle extension for odd ratios; clk_p is low across every boundary so this never moves a rising edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) clk_n <= 1'b0;
      else        clk_n <= clk_p;
   end

   assign clk_out = clk_p | (cur_div[0] & clk_n);

`ifdef CLK_DIV_CTRL_PERIOD_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         period_cnt <= '0;
      else if (period_start && (period_cnt != 16'hFFFF))
         period_cnt <= period_cnt + 16'd1;
   end
`else
   assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveform widths, boundary-aligned ratio changes, stop/restart, reset.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        div_req;
   logic [7:0]  div_val;
   logic        div_ack;
   logic        div_err;
   logic [7:0]  cur_div;
   logic        clk_out;
   logic        period_start;
   logic        busy;
   logic [15:0] period_cnt;

   int  n_chk  = 0;
   int  n_pass = 0;
   time t_rise = 0;
   time t_fall = 0;
   int  hi_w   = 0;
   int  lo_w   = 0;
   int  per_w  = 0;

   clk_div_ctrl #(.CNT_W(8), .DEF_DIV(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .div_req      (div_req),
      .div_val      (div_val),
      .div_ack      (div_ack),
      .div_err      (div_err),
      .cur_div      (cur_div),
      .clk_out      (clk_out),
      .period_start (period_start),
      .busy         (busy),
      .period_cnt   (period_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk_out) begin
      per_w  = int'($time - t_rise);
      lo_w   = int'($time - t_fall);
      t_rise = $time;
   end

   always @(negedge clk_out) begin
      hi_w   = int'($time - t_rise);
      t_fall = $time;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ps(input int max_cyc);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!period_start && k < max_cyc);
      if (!period_start) chk("period_start_timeout", 0, 1);
   endtask

   task automatic wait_ack(input int max_cyc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!div_ack && n < max_cyc);
   endtask

   initial begin
      int n;
      int cnt_ev;
      rst_n   = 1'b0;
      en      = 1'b0;
      div_req = 1'b0;
      div_val = 8'd0;

      #12;
      chk("rst_clk_out", clk_out, 0);
      chk("rst_cur_div", cur_div, 3);
      chk("rst_busy", busy, 0);
      chk("rst_ack", div_ack, 0);
      chk("rst_period_cnt", period_cnt, 0);
      #10 rst_n = 1'b1;
      tick();
      tick();

      // start with default ratio 3
      en = 1'b1;
      tick();
      chk("start_busy", busy, 1);
      chk("start_clk_low", clk_out, 0);
      tick();
      chk("first_rise", clk_out, 1);
      chk("first_ps", period_start, 1);
      cnt_ev = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (period_start) cnt_ev++;
      end
      chk("ps_every_3", cnt_ev, 3);
      chk("n3_high", hi_w, 15);
      chk("n3_low", lo_w, 15);
      chk("n3_period", per_w, 30);

      // illegal ratio: ack+err at boundary, held request not re-accepted
      div_req = 1'b1;
      div_val = 8'd1;
      wait_ack(10, n);
      chk("err_ack_latency", n, 3);
      chk("err_ack", div_ack, 1);
      chk("err_flag", div_err, 1);
      chk("err_cur_div", cur_div, 3);
      cnt_ev = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (div_ack) cnt_ev++;
      end
      chk("held_req_no_reack", cnt_ev, 0);
      div_req = 1'b0;
      wait_ps(10);
      chk("err_period_kept", per_w, 30);

      // ratio 4 requested mid-period
      div_req = 1'b1;
      div_val = 8'd4;
      wait_ack(10, n);
      chk("n4_ack_latency", n, 3);
      chk("n4_ack_at_ps", period_start, 1);
      chk("n4_no_err", div_err, 0);
      chk("n4_cur_div", cur_div, 4);
      div_req = 1'b0;
      wait_ps(10);
      chk("n4_high", hi_w, 20);
      chk("n4_low", lo_w, 20);
      chk("n4_period", per_w, 40);

      // ratio 6, drop en during high phase
      div_req = 1'b1;
      div_val = 8'd6;
      wait_ack(10, n);
      chk("n6_cur_div", cur_div, 6);
      div_req = 1'b0;
      tick();
      en = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 20);
      chk("stop_busy_fall", n, 5);
      chk("stop_high", hi_w, 30);
      chk("stop_clk_low", clk_out, 0);
      cnt_ev = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (period_start || clk_out) cnt_ev++;
      end
      chk("idle_quiet", cnt_ev, 0);

      // re-raise en before boundary: no gap
      en = 1'b1;
      wait_ps(10);
      tick();
      en = 1'b0;
      tick();
      tick();
      en = 1'b1;
      wait_ps(10);
      chk("resume_period", per_w, 60);
      chk("resume_low", lo_w, 30);
      chk("resume_busy", busy, 1);

      // request and stop meet at the same boundary
      div_req = 1'b1;
      div_val = 8'd5;
      tick();
      en = 1'b0;
      wait_ack(10, n);
      chk("stopreq_latency", n, 5);
      chk("stopreq_busy", busy, 0);
      chk("stopreq_cur_div", cur_div, 5);
      div_req = 1'b0;
      tick();
      tick();
      tick();
      chk("stopreq_idle", clk_out, 0);
      en = 1'b1;
      wait_ps(10);
      wait_ps(10);
      chk("n5_high", hi_w, 25);
      chk("n5_low", lo_w, 25);
      chk("n5_period", per_w, 50);

      // reset during high phase with a pending request
      div_req = 1'b1;
      div_val = 8'd7;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_clk_out", clk_out, 0);
      chk("arst_cur_div", cur_div, 3);
      chk("arst_busy", busy, 0);
      chk("arst_period_cnt", period_cnt, 0);
      en = 1'b0;
      #10 rst_n = 1'b1;
      cnt_ev = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (div_ack) cnt_ev++;
      end
      chk("arst_req_dropped", cnt_ev, 0);
      chk("arst_cur_div_kept", cur_div, 3);
      div_req = 1'b0;
      tick();

      // request and en together in IDLE: first period uses new ratio
      div_req = 1'b1;
      div_val = 8'd2;
      en      = 1'b1;
      tick();
      chk("idle_ack", div_ack, 1);
      chk("idle_cur_div", cur_div, 2);
      div_req = 1'b0;
      for (int i = 0; i < 10; i++) wait_ps(10);
      chk("n2_high", hi_w, 10);
      chk("n2_low", lo_w, 10);
      chk("n2_period", per_w, 20);
      tick();
`ifdef CLK_DIV_CTRL_PERIOD_STAT_EN
      chk("period_cnt_10", period_cnt, 10);
`else
      chk("period_cnt_tied", period_cnt, 0);
`endif

      en = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
